tt_sweep_capture: RTL and testbench
===================================

TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 Parameter N_IN, default 7: number of function inputs swept; the only supported value is 7.
REQ-002 Parameter TT_W, default 128: truth-table width, fixed at 2**N_IN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new sweep; sampled only in IDLE.
REQ-006 f_in  input  1  combinational output of the 7-input function under test, driven from x.
REQ-007 x  output  7  registered input vector driven to the function under test; x[0] maps to input x0, x[6] to x6.
REQ-008 busy  output  1  high while a sweep or evaluation is in progress.
REQ-009 done  output  1  one-cycle pulse when all results are valid.
REQ-010 tt  output  128  captured truth table; tt[i] = f(x=i).
REQ-011 ones  output  8  count of 1 bits in tt, range 0..128.
REQ-012 is_const  output  1  tt all-0 or all-1.
REQ-013 self_dual  output  1  tt[i] != tt[127-i] for all i.

Function
REQ-014 FSM states SHALL be IDLE, SWEEP, EVAL, DONE.
REQ-015 IDLE: on edge E0 with start=1, go to SWEEP; set idx=0, x=0; clear tt and ones; set busy=1.
REQ-016 In IDLE, start=0 SHALL hold all outputs unchanged.
REQ-017 In SWEEP, each edge SHALL write f_in into tt[idx], add f_in to ones, and set idx and x to idx+1.
REQ-018 f_in SHALL be sampled while x=idx; the function under test has one full cycle of settling time.
REQ-019 The edge that samples idx=127 (E128) SHALL move to EVAL and set x=0; idx SHALL NOT wrap into a further sample.
REQ-020 At edge E129 the EVAL state SHALL register is_const and self_dual from the complete tt, move to DONE, set done=1 and set busy=0.
REQ-021 At edge E130, DONE SHALL clear done and return to IDLE.
REQ-022 Total latency: done is high only during the cycle between E129 and E130.
REQ-023 start asserted in SWEEP, EVAL or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 tt, ones, is_const and self_dual SHALL hold their values from done until the next accepted start.
REQ-025 ones SHALL be 8 bits wide so that a count of 128 does not overflow.
REQ-026 x SHALL be 0 in every state except SWEEP.

Reset
REQ-027 rst=1 SHALL force IDLE, idx=0, x=0, busy=0, done=0, tt=0, ones=0, is_const=0 and self_dual=0 at the next edge.
REQ-028 rst SHALL take priority over start and over every state transition.
REQ-029 rst during SWEEP or EVAL SHALL abort the sweep, discard partial results and produce no done pulse.

Structure
REQ-030 Package tt_pkg SHALL hold N_IN, TT_W, the state enum and the ones width.
REQ-031 The self_dual and is_const reductions SHALL live in one combinational sub-module, tt_props, which takes tt and returns both flags.
REQ-032 The function under test SHALL stay external; the bench connects it between x and f_in.

Verification
REQ-033 Test 1: f_in = 0, start pulse -> done at E129; tt=0, ones=0, is_const=1, self_dual=0.
REQ-034 Test 2: f_in = x[0] -> tt=0xAAAA...AA, ones=64, is_const=0, self_dual=1.
REQ-035 Test 3: f_in = x[0]&x[1] -> tt=0x8888...88, ones=32, self_dual=0.
REQ-036 Test 4: f_in = majority(x[0],x[1],x[6]) -> ones=64, self_dual=1, is_const=0.
REQ-037 Test 5: start re-pulsed at E40 and E129 -> ignored both times; exactly one done, results identical to a clean run.
REQ-038 Test 6: rst at E50 of a sweep -> next cycle busy=0, x=0, tt=0, ones=0; no done; a fresh start then completes normally.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared constants and state encoding for the truth-table sweep/capture block.
package tt_pkg;

    localparam int N_IN   = 7;
    localparam int TT_W   = 1 << N_IN;
    localparam int ONES_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        EVAL,
        DONE
    } state_e;

endpackage

// File: rtl/tt_props.sv
// Combinational structural properties of a captured truth table.
module tt_props
    import tt_pkg::*;
#(
    parameter int TT_W = tt_pkg::TT_W
) (
    input  logic [TT_W-1:0] tt,
    output logic            is_const,
    output logic            self_dual
);

    // Self-dual means f(~x) == ~f(x); index TT_W-1-i is the bitwise complement of i.
    always_comb begin
        is_const  = (tt == '0) || (tt == '1);
        self_dual = 1'b1;
        for (int i = 0; i < TT_W / 2; i++) begin
            if (tt[i] == tt[TT_W-1-i]) begin
                self_dual = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives every input vector of an external 7-input function, captures its truth
// table, and reports the number of ones plus constant / self-dual flags.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int N_IN = tt_pkg::N_IN,
    parameter int TT_W = tt_pkg::TT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              f_in,
    output logic [N_IN-1:0]   x,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt,
    output logic [ONES_W-1:0] ones,
    output logic              is_const,
    output logic              self_dual
);

    state_e              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [N_IN-1:0]     x_q, x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [TT_W-1:0]     tt_q, tt_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                is_const_q, is_const_d;
    logic                self_dual_q, self_dual_d;
    logic                props_const;
    logic                props_self_dual;

    tt_props #(
        .TT_W (TT_W)
    ) u_tt_props (
        .tt        (tt_q),
        .is_const  (props_const),
        .self_dual (props_self_dual)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tt_d        = tt_q;
        ones_d      = ones_q;
        is_const_d  = is_const_q;
        self_dual_d = self_dual_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    x_d     = '0;
                    tt_d    = '0;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                // x has equalled idx for a full cycle, so f_in has settled.
                tt_d[idx_q] = f_in;
                ones_d      = ones_q + {{(ONES_W-1){1'b0}}, f_in};
                if (idx_q == '1) begin
                    state_d = EVAL;
                    idx_d   = '0;
                    x_d     = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                    x_d   = idx_q + 1'b1;
                end
            end
            EVAL: begin
                is_const_d  = props_const;
                self_dual_d = props_self_dual;
                state_d     = DONE;
                done_d      = 1'b1;
                busy_d      = 1'b0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the truth table is a plain register, not a memory, so it is cleared on reset with everything else.
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tt_q        <= '0;
            ones_q      <= '0;
            is_const_q  <= 1'b0;
            self_dual_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tt_q        <= tt_d;
            ones_q      <= ones_d;
            is_const_q  <= is_const_d;
            self_dual_q <= self_dual_d;
        end
    end

    assign x         = x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tt        = tt_q;
    assign ones      = ones_q;
    assign is_const  = is_const_q;
    assign self_dual = self_dual_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench: cycle-level behavioural model plus hand-computed expectations.
module tb_tt_sweep_capture;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         f_in;
    logic [6:0]   x;
    logic         busy;
    logic         done;
    logic [127:0] tt;
    logic [7:0]   ones;
    logic         is_const;
    logic         self_dual;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_done   = 0;
    int           fsel     = 0;
    logic [127:0] rand_tt  = '0;

    always #5 clk = ~clk;

    tt_sweep_capture dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .f_in      (f_in),
        .x         (x),
        .busy      (busy),
        .done      (done),
        .tt        (tt),
        .ones      (ones),
        .is_const  (is_const),
        .self_dual (self_dual)
    );

    // Functions under test, selected by fsel.
    function automatic logic f_model(input int sel, input logic [6:0] v, input logic [127:0] tbl);
        case (sel)
            1:       return v[0];
            2:       return v[0] & v[1];
            3:       return (v[0] & v[1]) | (v[0] & v[6]) | (v[1] & v[6]);
            4:       return tbl[v];
            5:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb f_in = f_model(fsel, x, rand_tt);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: m_cnt = edges since the accepted start (-1 when idle).
    int           m_cnt   = -1;
    logic [127:0] m_tt    = '0;
    logic         m_const = 1'b0;
    logic         m_sd    = 1'b0;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = -1;
            m_tt    = '0;
            m_const = 1'b0;
            m_sd    = 1'b0;
            m_valid = 1'b1;
        end else if (m_cnt < 0) begin
            if (start) begin
                m_cnt = 0;
                m_tt  = '0;
            end
        end else if (m_cnt < 128) begin
            m_tt[m_cnt] = f_model(fsel, 7'(m_cnt), rand_tt);
            m_cnt++;
        end else if (m_cnt == 128) begin
            m_const = ($countones(m_tt) == 0) || ($countones(m_tt) == 128);
            m_sd    = 1'b1;
            for (int i = 0; i < 128; i++) begin
                if (m_tt[i] == m_tt[127-i]) m_sd = 1'b0;
            end
            m_cnt = 129;
        end else begin
            m_cnt = -1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("x",         128'(x),         (m_cnt >= 0 && m_cnt < 128) ? 128'(m_cnt) : 128'd0);
            check("busy",      128'(busy),      128'(m_cnt >= 0 && m_cnt <= 128));
            check("done",      128'(done),      128'(m_cnt == 129));
            check("tt",        tt,              m_tt);
            check("ones",      128'(ones),      128'($countones(m_tt)));
            check("is_const",  128'(is_const),  128'(m_const));
            check("self_dual", 128'(self_dual), 128'(m_sd));
            if (done) n_done++;
        end
    end

    // lat counts negedges after the start edge E0; negedge k follows edge E(k-1).
    task automatic run_sweep(input int sel, input bit repulse, input int rst_at, output int lat);
        fsel  = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (lat < 300) begin
            if (done) break;
            if (rst_at > 0 && lat == rst_at + 1) begin
                check("rst_busy", 128'(busy), 128'd0);
                check("rst_x",    128'(x),    128'd0);
                check("rst_tt",   tt,         128'd0);
                check("rst_ones", 128'(ones), 128'd0);
            end
            start = repulse && (lat == 40 || lat == 129);
            rst   = (lat == rst_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        int           lat;
        int           d0;
        logic [127:0] exp_tt;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",      128'(busy),      128'd0);
        check("reset_done",      128'(done),      128'd0);
        check("reset_x",         128'(x),         128'd0);
        check("reset_tt",        tt,              128'd0);
        check("reset_ones",      128'(ones),      128'd0);
        check("reset_is_const",  128'(is_const),  128'd0);
        check("reset_self_dual", 128'(self_dual), 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: constant zero
        d0 = n_done;
        run_sweep(0, 1'b0, -1, lat);
        check("t1_latency",   128'(lat),        128'd130);
        check("t1_tt",        tt,               128'd0);
        check("t1_ones",      128'(ones),       128'd0);
        check("t1_is_const",  128'(is_const),   128'd1);
        check("t1_self_dual", 128'(self_dual),  128'd0);
        @(negedge clk);
        check("t1_done_pulse", 128'(n_done - d0), 128'd1);
        check("t1_done_clear", 128'(done),         128'd0);

        // Test 2: f = x0
        exp_tt = {64{2'b10}};
        run_sweep(1, 1'b0, -1, lat);
        check("t2_tt",        tt,              exp_tt);
        check("t2_ones",      128'(ones),      128'd64);
        check("t2_is_const",  128'(is_const),  128'd0);
        check("t2_self_dual", 128'(self_dual), 128'd1);
        repeat (3) @(negedge clk);

        // Test 3: f = x0 & x1
        exp_tt = {32{4'b1000}};
        run_sweep(2, 1'b0, -1, lat);
        check("t3_tt",        tt,              exp_tt);
        check("t3_ones",      128'(ones),      128'd32);
        check("t3_self_dual", 128'(self_dual), 128'd0);
        repeat (2) @(negedge clk);

        // Test 4: majority(x0, x1, x6)
        run_sweep(3, 1'b0, -1, lat);
        check("t4_ones",      128'(ones),      128'd64);
        check("t4_self_dual", 128'(self_dual), 128'd1);
        check("t4_is_const",  128'(is_const),  128'd0);
        repeat (2) @(negedge clk);

        // Test 5: start re-pulsed at E40 and E129 is neither honoured nor queued
        d0     = n_done;
        exp_tt = {32{4'b1000}};
        run_sweep(2, 1'b1, -1, lat);
        check("t5_latency", 128'(lat),  128'd130);
        check("t5_tt",      tt,         exp_tt);
        check("t5_ones",    128'(ones), 128'd32);
        repeat (20) @(negedge clk);
        check("t5_one_done", 128'(n_done - d0), 128'd1);
        check("t5_idle",     128'(busy),        128'd0);
        check("t5_hold_tt",  tt,                exp_tt);

        // Test 6: reset at E50 aborts, then a fresh sweep completes
        d0 = n_done;
        run_sweep(1, 1'b0, 50, lat);
        check("t6_no_done", 128'(n_done - d0), 128'd0);
        exp_tt = {64{2'b10}};
        run_sweep(1, 1'b0, -1, lat);
        check("t6_latency", 128'(lat), 128'd130);
        check("t6_tt",      tt,        exp_tt);
        repeat (2) @(negedge clk);

        // Constant one: ones must reach 128 without overflow
        run_sweep(5, 1'b0, -1, lat);
        check("t7_tt",       tt,             {128{1'b1}});
        check("t7_ones",     128'(ones),     128'd128);
        check("t7_is_const", 128'(is_const), 128'd1);
        repeat (2) @(negedge clk);

        // Random truth tables with random idle gaps and stray start pulses
        for (int r = 0; r < 6; r++) begin
            rand_tt = {$urandom(), $urandom(), $urandom(), $urandom()};
            repeat ($urandom_range(1, 8)) @(negedge clk);
            run_sweep(4, 1'($urandom_range(0, 1)), -1, lat);
            check("rnd_latency", 128'(lat),  128'd130);
            check("rnd_tt",      tt,         rand_tt);
            check("rnd_ones",    128'(ones), 128'($countones(rand_tt)));
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
